// File: rtl/reg_ctrl_arbiter.sv
// reg_ctrl_arbiter
//   Round-robin arbiter that shares one reg_ctrl register-file port between
//   NUM_REQ requesters. Each requester issues single read/write commands and
//   receives a one-cycle completion pulse. The arbiter owns the downstream
//   sel/wr sequencing, including the ready-recovery cycle after every read.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_wr     per-requester command valid / write(1) read(0)
//   req_addr/req_wdata   packed per-requester address / write data
//   req_ready            one-hot command accept (combinational, IDLE only)
//   rsp_valid            one-hot completion pulse
//   rsp_rdata            read data with rsp_valid (0 for writes and when idle)
//   m_addr/m_sel/m_wr/m_wdata/m_rdata/m_ready   register-file port
//
// Timing (grant at cycle T)
//   write: WR at T+1, rsp_valid at T+2
//   read : RD_ISSUE at T+1 (accepted), RD_WAIT at T+2 (rdata valid),
//          rsp_valid at T+3
module reg_ctrl_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic                             m_sel,
  output logic                             m_wr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] lo_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic               grant;

  // Flat buses reinterpreted as per-requester packed arrays (same bit layout).
  assign addr_arr  = req_addr;
  assign wdata_arr = req_wdata;

  // Requesters at or above rr_ptr form the preferred group; the rest are the
  // wrap-around group searched only when the preferred group is empty.
  assign lo_mask = (NUM_REQ'(1) << rr_ptr) - NUM_REQ'(1);
  assign hi_req  = req_valid & ~lo_mask;

  // Lowest set bit of the preferred group, else lowest set bit overall.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win_idx = IDX_W'(i);
    end
    if (|hi_req) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (hi_req[i]) win_idx = IDX_W'(i);
      end
    end
  end

  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // Grants only when the register file is ready so the command issued next
  // cycle is not stalled from the start.
  assign grant     = (state == IDLE) && m_ready && (|req_valid);
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;

  // m_sel stays high through RD_WAIT: the register file restores ready on
  // sel while ready is low, and dropping sel right after IDLE prevents a
  // second read being accepted.
  assign m_sel = (state != IDLE);
  assign m_wr  = (state == WR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant) state_nxt = req_wr[win_idx] ? WR : RD_ISSUE;
      WR:       if (m_ready) state_nxt = IDLE;
      RD_ISSUE: if (m_ready) state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      if (grant) begin
        owner   <= win_idx;
        rr_ptr  <= next_ptr;
        m_addr  <= addr_arr[win_idx];
        m_wdata <= wdata_arr[win_idx];
      end
      if (state == WR && m_ready) begin
        rsp_valid <= NUM_REQ'(1) << owner;
      end
      if (state == RD_WAIT) begin
        rsp_valid <= NUM_REQ'(1) << owner;
        rsp_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_reg_ctrl_arbiter.sv
// Bench for reg_ctrl_arbiter: register-file model, queue-driven requesters,
// a transaction-level reference model compared every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_reg_ctrl_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, m_wdata, m_rdata;
  logic [AW-1:0]   m_addr;
  logic            m_sel, m_wr, m_ready;

  reg_ctrl_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m_addr(m_addr), .m_sel(m_sel), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file model ----------------
  // Every register resets to 16'h1234. Ready drops after a read is accepted
  // and comes back only on a cycle where sel is still high.
  logic          stall = 1'b0;
  logic          rf_rdy;
  logic [DW-1:0] rf_rdata = '0;
  logic [DW-1:0] rf_mem [256] = '{default: 16'h1234};
  int            rd_cnt = 0;

  assign m_ready = rf_rdy & ~stall;
  assign m_rdata = rf_rdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rf_rdy <= 1'b1;
    else if (m_sel && m_ready) begin
      if (m_wr) rf_mem[m_addr] <= m_wdata;
      else begin
        rf_rdata <= rf_mem[m_addr];
        rf_rdy   <= 1'b0;
        rd_cnt   <= rd_cnt + 1;
      end
    end else if (m_sel && !rf_rdy) rf_rdy <= 1'b1;
  end

  // ---------------- requesters ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;
  cmd_t cq [N][$];

  task automatic push(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.wr = wr; c.a = a; c.d = d;
    cq[i].push_back(c);
  endtask

  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        if (cq[i].size() > 0) begin
          req_valid[i]             = 1'b1;
          req_wr[i]                = cq[i][0].wr;
          req_addr[i*AW +: AW]     = cq[i][0].a;
          req_wdata[i*DW +: DW]    = cq[i][0].d;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model + compare + logs ----------------
  // The model tracks one outstanding transaction: which requester owns the
  // port, whether it is a write, and whether a read has already been taken
  // by the register file (then one drain cycle precedes the response).
  // Read data comes from the model's own memory, updated by granted writes.
  logic [DW-1:0] smem [256] = '{default: 16'h1234};
  logic          mdl_active = 1'b0, mdl_wr = 1'b0, mdl_acc = 1'b0;
  int            mdl_owner = 0, mdl_rr = 0;
  logic [AW-1:0] mdl_a = '0, e_addr = '0;
  logic [DW-1:0] mdl_d = '0, e_wdata = '0, e_rdata = '0;
  logic [N-1:0]  e_rsp = '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gnt_id[$], gnt_cyc[$], rsp_id[$], rsp_cyc[$], wsel_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  int sel_cnt = 0;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  initial begin
    int w;
    logic [N-1:0]  nrsp;
    logic [DW-1:0] nrd;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mdl_active = 0; mdl_acc = 0; mdl_rr = 0;
        e_addr = '0; e_wdata = '0; e_rsp = '0; e_rdata = '0;
      end else begin
        w = (!mdl_active && m_ready) ? rr_pick(req_valid, mdl_rr) : -1;
        chk("req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("m_sel", m_sel, mdl_active);
        chk("m_wr", m_wr, mdl_active && mdl_wr);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rsp_rdata", rsp_rdata, e_rdata);

        if (|req_ready) begin gnt_id.push_back(onehot_idx(req_ready)); gnt_cyc.push_back(cyc); end
        if (|rsp_valid) begin
          rsp_id.push_back(onehot_idx(rsp_valid)); rsp_cyc.push_back(cyc); rsp_dat.push_back(rsp_rdata);
        end
        if (m_sel && m_wr) wsel_cyc.push_back(cyc);
        if (m_sel) sel_cnt++;

        nrsp = '0; nrd = '0;
        if (!mdl_active) begin
          if (w >= 0) begin
            mdl_active = 1; mdl_acc = 0; mdl_owner = w;
            mdl_wr = req_wr[w]; mdl_a = req_addr[w*AW +: AW]; mdl_d = req_wdata[w*DW +: DW];
            e_addr = mdl_a; e_wdata = mdl_d;
            mdl_rr = (w + 1) % N;
          end
        end else if (mdl_acc) begin
          nrsp = N'(1) << mdl_owner; nrd = smem[mdl_a]; mdl_active = 0;
        end else if (m_ready) begin
          if (mdl_wr) begin
            smem[mdl_a] = mdl_d; nrsp = N'(1) << mdl_owner; mdl_active = 0;
          end else mdl_acc = 1;
        end
        e_rsp = nrsp; e_rdata = nrd;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    gnt_id.delete(); gnt_cyc.delete(); rsp_id.delete(); rsp_cyc.delete();
    rsp_dat.delete(); wsel_cyc.delete(); sel_cnt = 0;
  endtask

  function automatic bit all_quiet();
    for (int i = 0; i < N; i++) if (cq[i].size() > 0) return 0;
    return (req_valid == '0) && !mdl_active && (e_rsp == '0) && (rsp_valid == '0);
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!all_quiet() && n < 400);
    chk({name, "_timeout"}, (n < 400), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int rd0, n;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("rst_m_sel", m_sel, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // Read after reset: req1 reads 0x05.
    clear_logs(); rd0 = rd_cnt;
    push(1, 0, 8'h05, 16'h0);
    wait_idle("rd_reset");
    chk("rdr_gnt_cnt", gnt_id.size(), 1);
    chk("rdr_gnt_id", gnt_id[0], 1);
    chk("rdr_rsp_id", rsp_id[0], 1);
    chk("rdr_rdata", rsp_dat[0], 16'h1234);
    chk("rdr_latency", rsp_cyc[0] - gnt_cyc[0], 3);
    chk("rdr_sel_cycles", sel_cnt, 2);
    chk("rdr_read_count", rd_cnt - rd0, 1);

    // Single write: req0 writes 0x10 = 0xBEEF.
    clear_logs();
    push(0, 1, 8'h10, 16'hBEEF);
    wait_idle("wr");
    chk("wr_gnt_id", gnt_id[0], 0);
    chk("wr_sel_wr_cyc", wsel_cyc[0] - gnt_cyc[0], 1);
    chk("wr_wsel_len", wsel_cyc.size(), 1);
    chk("wr_latency", rsp_cyc[0] - gnt_cyc[0], 2);
    chk("wr_rsp_id", rsp_id[0], 0);
    chk("wr_rdata", rsp_dat[0], 0);

    // Read back by req2.
    clear_logs();
    push(2, 0, 8'h10, 16'h0);
    wait_idle("rdback");
    chk("rdb_rsp_id", rsp_id[0], 2);
    chk("rdb_rdata", rsp_dat[0], 16'hBEEF);
    chk("rdb_latency", rsp_cyc[0] - gnt_cyc[0], 3);

    // Mixed contention from reset.
    do_reset();
    clear_logs();
    push(0, 1, 8'h01, 16'h00AA);
    push(3, 0, 8'h01, 16'h0);
    wait_idle("mixed");
    chk("mix_gnt0", gnt_id[0], 0);
    chk("mix_gnt1", gnt_id[1], 3);
    chk("mix_spacing", gnt_cyc[1] - gnt_cyc[0], 2);
    chk("mix_rsp_id", rsp_id[1], 3);
    chk("mix_rdata", rsp_dat[1], 16'h00AA);

    // Round-robin fairness: all four hold reads continuously.
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 0, 8'(8'h20 + i), 16'h0);
    wait_idle("rr");
    chk("rr_gnt_cnt", gnt_id.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("rr_gnt_order", gnt_id[k], k % 4);
      chk("rr_rsp_owner", rsp_id[k], k % 4);
      if (k > 0) chk("rr_spacing", gnt_cyc[k] - gnt_cyc[k-1], 3);
    end

    // Stall: ready forced low for 5 cycles with req2 pending.
    clear_logs(); rd0 = rd_cnt;
    @(posedge clk); #2 stall = 1'b1;
    push(2, 0, 8'h10, 16'h0);
    repeat (5) begin @(negedge clk); chk("stall_no_ready", req_ready, 0); end
    @(posedge clk); #2 stall = 1'b0;
    wait_idle("stall");
    chk("stall_gnt_cnt", gnt_id.size(), 1);
    chk("stall_gnt_id", gnt_id[0], 2);
    chk("stall_rsp_cnt", rsp_id.size(), 1);
    chk("stall_rdata", rsp_dat[0], 16'hBEEF);
    chk("stall_read_count", rd_cnt - rd0, 1);

    // Reset in RD_WAIT: req1 read, reset two cycles after grant.
    clear_logs();
    push(1, 0, 8'h05, 16'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
    chk("rmid_grant_seen", req_ready[1], 1);
    @(negedge clk);
    @(negedge clk);
    chk("rmid_sel_before", m_sel, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rmid_m_sel", m_sel, 0);
    chk("rmid_m_wr", m_wr, 0);
    chk("rmid_rsp_valid", rsp_valid, 0);
    chk("rmid_m_addr", m_addr, 0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    chk("rmid_no_rsp", rsp_id.size(), 0);
    clear_logs();
    push(2, 0, 8'h05, 16'h0);
    push(0, 0, 8'h10, 16'h0);
    wait_idle("after_rst");
    chk("ar_gnt0", gnt_id[0], 0);
    chk("ar_gnt1", gnt_id[1], 2);
    chk("ar_rsp_cnt", rsp_id.size(), 2);
    chk("ar_rdata0", rsp_dat[0], 16'hBEEF);
    chk("ar_rdata1", rsp_dat[1], 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
